time_cnt24: RTL and testbench
=============================

TIME_CNT24 -- requirements
Module: time_cnt24

Interface
REQ-001 The block SHALL expose the following ports:
- CLK      input   1  system clock; all state changes on its rising edge
- RST      input   1  asynchronous, active-low reset
- EN1HZ    input   1  one-cycle 1 Hz count enable pulse
- SECCLR   input   1  seconds-clear request from the adjust state machine
- MININC   input   1  minutes-increment request from the adjust state machine
- HOURINC  input   1  hours-increment request from the adjust state machine
- SEC      output  8  seconds, BCD: [7:4] tens 0-5, [3:0] units 0-9
- MIN      output  8  minutes, BCD, same encoding as SEC
- HOUR     output  8  hours, BCD: tens 0-2, units 0-9, range 00-23
- DAYCARRY output  1  one-cycle pulse on 23:59:59 -> 00:00:00 rollover
REQ-002 The block SHALL have no parameters; the 24-hour format is fixed.

Function
REQ-003 All outputs SHALL be registered; each reacts on the first CLK edge that samples its causing input high, with no further latency.
REQ-004 Seconds SHALL advance by 1 on each cycle with EN1HZ=1; units 9 goes to 0 and increments tens; 59 goes to 00 and asserts an internal minute carry in the same cycle.
REQ-005 Minutes SHALL advance by 1 when the minute carry=1 or MININC=1; two simultaneous causes SHALL produce a single increment.
REQ-006 Minutes 59 -> 00 SHALL raise an internal hour carry only when caused by the minute carry; a wrap caused by MININC alone SHALL NOT raise it.
REQ-007 Hours SHALL advance by 1 when the hour carry=1 or HOURINC=1, again as a single increment; 09 -> 10, 19 -> 20, 23 -> 00.
REQ-008 A wrap caused by HOURINC alone SHALL NOT assert DAYCARRY.
REQ-009 DAYCARRY SHALL be high for exactly one cycle, in the cycle after the EN1HZ edge that takes 23:59:59 to 00:00:00.
REQ-010 SECCLR=1 SHALL load SEC=00 and suppress any minute carry in that cycle; SECCLR SHALL take priority over EN1HZ.
REQ-011 The request inputs SHALL be level-sampled every cycle; a request held for N cycles SHALL apply N times, because the upstream block generates single-cycle pulses.
REQ-012 Any illegal BCD value in a field (units >9, seconds/minutes tens >5, hours >23) SHALL be replaced by 00 on that field's next increment.
REQ-013 With no EN1HZ, SECCLR, MININC or HOURINC active, all fields SHALL hold and DAYCARRY SHALL be 0.

Reset
REQ-014 RST=0 SHALL asynchronously force SEC=00, MIN=00, HOUR=00 and DAYCARRY=0, independent of CLK.
REQ-015 Reset deassertion SHALL be synchronised externally; the first counting edge SHALL be the first CLK edge with RST=1.
REQ-016 Reset asserted in the middle of a carry chain SHALL leave no pending carry; after reset the state SHALL be exactly 00:00:00.

Structure
REQ-017 A shared package SHALL hold the BCD field width (8), the limits SEC_MAX=8'h59, MIN_MAX=8'h59 and HOUR_MAX=8'h23, and the illegal-value check.
REQ-018 One sub-module, bcd_cnt_mod (inputs: inc, clr, max; outputs: value, wrap), SHALL be instantiated three times, once each for seconds, minutes and hours.
REQ-019 Carry logic SHALL be combinational between the instances, so a full rollover completes in a single cycle.

Verification
REQ-020 Release reset, apply 60 EN1HZ pulses -> SEC=00, MIN=01, HOUR=00, DAYCARRY never high.
REQ-021 Preload 23:59:58 via MININC/HOURINC, apply 2 EN1HZ pulses -> 23:59:59, then 00:00:00 with DAYCARRY high for exactly 1 cycle.
REQ-022 From 00:59:30, apply MININC -> 00:00:30 with HOUR unchanged at 00; from 23:00:00, apply HOURINC -> 00:00:00 with DAYCARRY=0.
REQ-023 At SEC=59, MIN=10, assert SECCLR and EN1HZ in the same cycle -> SEC=00, MIN=10.
REQ-024 At SEC=59, MIN=10, assert MININC and EN1HZ in the same cycle -> SEC=00, MIN=11 (single increment).
REQ-025 Drive RST=0 between CLK edges from 12:34:56 -> outputs read 00:00:00 before the next edge; EN1HZ held high for 3 cycles after release -> SEC=03.

Source files
------------

// File: rtl/time_cnt24_pkg.sv
// Shared definitions for the 24-hour BCD time-of-day counter.
package time_cnt24_pkg;

  localparam int unsigned BCD_W = 8;

  localparam logic [BCD_W-1:0] SEC_MAX  = 8'h59;
  localparam logic [BCD_W-1:0] MIN_MAX  = 8'h59;
  localparam logic [BCD_W-1:0] HOUR_MAX = 8'h23;

  // A field is illegal when its units digit is not a decimal digit or the
  // whole value is beyond the field limit. Legal BCD orders the same way as
  // binary, so one magnitude compare covers both the tens digit and the
  // 24..29 hours that have legal digits.
  function automatic logic bcd_illegal(input logic [BCD_W-1:0] v,
                                       input logic [BCD_W-1:0] max);
    return (v[3:0] > 4'd9) || (v > max);
  endfunction

endpackage

// File: rtl/time_cnt24_bcd.sv
// Two-digit BCD counter with synchronous clear, run-time limit and
// combinational wrap flag so carries ripple through a chain in one cycle.
module bcd_cnt_mod
  import time_cnt24_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  input  logic             clr,
  input  logic [BCD_W-1:0] max,
  output logic [BCD_W-1:0] value,
  output logic             wrap
);

  logic [BCD_W-1:0] nxt;
  logic             at_max;

  // Next count value and wrap flag for the current request.
  always_comb begin
    nxt    = '0;
    at_max = (value == max);
    if (at_max || bcd_illegal(value, max)) begin
      nxt = '0;
    end else if (value[3:0] == 4'd9) begin
      nxt = {value[7:4] + 4'd1, 4'h0};
    end else begin
      nxt = {value[7:4], value[3:0] + 4'd1};
    end
    // An illegal value reloads 00 but is not a rollover, so no carry.
    wrap = inc && !clr && at_max;
  end

  // Field register: clear wins over increment.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= nxt;
    end
  end

endmodule

// File: rtl/time_cnt24.sv
// 24-hour BCD clock: seconds, minutes, hours with adjust requests and a
// one-cycle day rollover pulse.
module time_cnt24
  import time_cnt24_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN1HZ,
  input  logic             SECCLR,
  input  logic             MININC,
  input  logic             HOURINC,
  output logic [BCD_W-1:0] SEC,
  output logic [BCD_W-1:0] MIN,
  output logic [BCD_W-1:0] HOUR,
  output logic             DAYCARRY
);

  logic sec_wrap, min_wrap, hour_wrap;
  logic min_inc, hour_inc;
  logic hour_carry, day_carry;

  // Carry chain: adjust requests OR with carries so coincident causes give a
  // single increment; only genuine carries propagate further up the chain.
  always_comb begin
    min_inc    = sec_wrap | MININC;
    hour_carry = min_wrap & sec_wrap;
    hour_inc   = hour_carry | HOURINC;
    day_carry  = hour_wrap & hour_carry;
  end

  bcd_cnt_mod u_sec (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (EN1HZ),
    .clr   (SECCLR),
    .max   (SEC_MAX),
    .value (SEC),
    .wrap  (sec_wrap)
  );

  bcd_cnt_mod u_min (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (min_inc),
    .clr   (1'b0),
    .max   (MIN_MAX),
    .value (MIN),
    .wrap  (min_wrap)
  );

  bcd_cnt_mod u_hour (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (hour_inc),
    .clr   (1'b0),
    .max   (HOUR_MAX),
    .value (HOUR),
    .wrap  (hour_wrap)
  );

  // Registered day rollover pulse.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      DAYCARRY <= 1'b0;
    end else begin
      DAYCARRY <= day_carry;
    end
  end

endmodule

// File: tb/tb_time_cnt24.sv
// Self-checking bench for time_cnt24: vector table plus scoreboarded
// sequences against a decimal reference model.
module tb_time_cnt24;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       EN1HZ = 1'b0, SECCLR = 1'b0, MININC = 1'b0, HOURINC = 1'b0;
  logic [7:0] SEC, MIN, HOUR;
  logic       DAYCARRY;

  int total = 0;
  int bad   = 0;

  time_cnt24 dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN1HZ    (EN1HZ),
    .SECCLR   (SECCLR),
    .MININC   (MININC),
    .HOURINC  (HOURINC),
    .SEC      (SEC),
    .MIN      (MIN),
    .HOUR     (HOUR),
    .DAYCARRY (DAYCARRY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       en, clr, mi, hi;
    logic [7:0] s, m, h;
    logic       d;
  } vec_t;

  typedef struct {
    logic [7:0] s, m, h;
    logic       d;
  } exp_t;

  exp_t sb[$];

  int  ms = 0, mm = 0, mh = 0;
  bit  mday = 1'b0;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic model(input bit en, input bit clr, input bit mi, input bit hi);
    bit sc = 1'b0;
    bit hc = 1'b0;
    if (clr) ms = 0;
    else if (en) begin
      if (ms == 59) begin ms = 0; sc = 1'b1; end
      else ms++;
    end
    if (sc || mi) begin
      if (mm == 59) begin mm = 0; hc = sc; end
      else mm++;
    end
    mday = 1'b0;
    if (hc || hi) begin
      if (mh == 23) begin mh = 0; mday = hc; end
      else mh++;
    end
  endtask

  // Drive one cycle from a negedge, push the model result, compare after the edge.
  task automatic step(input bit en, input bit clr, input bit mi, input bit hi, input bit quiet);
    exp_t e;
    EN1HZ = en; SECCLR = clr; MININC = mi; HOURINC = hi;
    model(en, clr, mi, hi);
    sb.push_back('{to_bcd(ms), to_bcd(mm), to_bcd(mh), mday});
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    if (!quiet) begin
      chk8("sec", SEC, e.s);
      chk8("min", MIN, e.m);
      chk8("hour", HOUR, e.h);
    end
    chk1("daycarry", DAYCARRY, e.d);
    @(negedge CLK);
    EN1HZ = 1'b0; SECCLR = 1'b0; MININC = 1'b0; HOURINC = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    ms = 0; mm = 0; mh = 0; mday = 1'b0;
    #1;
    chk8("rst_sec", SEC, 8'h00);
    chk8("rst_min", MIN, 8'h00);
    chk8("rst_hour", HOUR, 8'h00);
    chk1("rst_day", DAYCARRY, 1'b0);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic preload(input int h, input int m, input int s);
    for (int unsigned i = 0; i < h; i++) step(0, 0, 0, 1, 1);
    for (int unsigned i = 0; i < m; i++) step(0, 0, 1, 0, 1);
    for (int unsigned i = 0; i < s; i++) step(1, 0, 0, 0, 1);
  endtask

  vec_t vt[8];

  initial begin
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'h00, 8'h00, 1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 8'h00, 1'b0};
    vt[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 8'h01, 8'h01, 1'b0};
    vt[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h01, 8'h01, 1'b0};
    vt[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 8'h01, 1'b0};
    vt[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 8'h01, 1'b0};
    vt[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 8'h02, 8'h02, 1'b0};
    vt[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h02, 8'h02, 8'h02, 1'b0};

    @(negedge CLK);
    do_reset();

    // Table vectors from 00:00:00.
    for (int unsigned i = 0; i < 8; i++) begin
      EN1HZ = vt[i].en; SECCLR = vt[i].clr; MININC = vt[i].mi; HOURINC = vt[i].hi;
      model(vt[i].en, vt[i].clr, vt[i].mi, vt[i].hi);
      @(posedge CLK);
      #1;
      chk8("tbl_sec", SEC, vt[i].s);
      chk8("tbl_min", MIN, vt[i].m);
      chk8("tbl_hour", HOUR, vt[i].h);
      chk1("tbl_day", DAYCARRY, vt[i].d);
      @(negedge CLK);
    end
    EN1HZ = 1'b0; SECCLR = 1'b0; MININC = 1'b0; HOURINC = 1'b0;

    // 60 seconds -> 00:01:00, no day carry.
    do_reset();
    for (int unsigned i = 0; i < 60; i++) step(1, 0, 0, 0, 0);
    chk8("60s_min", MIN, 8'h01);

    // 23:59:58 -> 23:59:59 -> 00:00:00 with one-cycle DAYCARRY.
    do_reset();
    preload(23, 59, 58);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk1("day_pulse", DAYCARRY, 1'b1);
    step(0, 0, 0, 0, 0);
    chk1("day_gone", DAYCARRY, 1'b0);

    // MININC wrap leaves hour alone.
    do_reset();
    preload(0, 59, 30);
    step(0, 0, 1, 0, 0);
    chk8("mininc_hour", HOUR, 8'h00);

    // HOURINC wrap gives no DAYCARRY.
    do_reset();
    preload(23, 0, 0);
    step(0, 0, 0, 1, 0);
    chk1("hourinc_day", DAYCARRY, 1'b0);

    // SECCLR beats EN1HZ and suppresses the minute carry.
    do_reset();
    preload(0, 10, 59);
    step(1, 1, 0, 0, 0);
    chk8("secclr_min", MIN, 8'h10);

    // Minute carry coincident with MININC is a single increment.
    do_reset();
    preload(0, 10, 59);
    step(1, 0, 1, 0, 0);
    chk8("dual_min", MIN, 8'h11);

    // Held request applies every cycle; carry across 09 -> 10 hours.
    do_reset();
    for (int unsigned i = 0; i < 10; i++) step(0, 0, 0, 1, 0);
    for (int unsigned i = 0; i < 10; i++) step(0, 0, 0, 1, 0);

    // Asynchronous reset between edges from 12:34:56.
    do_reset();
    preload(12, 34, 56);
    chk8("pre_sec", SEC, 8'h56);
    #2;
    do_reset();
    for (int unsigned i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    chk8("post_rst_sec", SEC, 8'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
